// File: rtl/instr_fetch_unit_if.sv
// PC / memory / decoder signal bundle for the instruction fetch unit.
// master = fetch unit view, slave = surrounding PC, memory and decoder.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] Address;
    logic              PCWre;
    logic              Flush;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] Instruction;
    logic [ADDR_W-1:0] InstrPC;
    logic              InstrValid;
    logic              InstrReady;
    logic              AddrErr;

    modport master (
        input  Address, Flush, mem_ack, mem_rdata, InstrReady,
        output PCWre, mem_req, mem_addr, Instruction, InstrPC, InstrValid, AddrErr
    );

    modport slave (
        output Address, Flush, mem_ack, mem_rdata, InstrReady,
        input  PCWre, mem_req, mem_addr, Instruction, InstrPC, InstrValid, AddrErr
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads the word at the current PC over a req/ack
// handshake, queues {PC, word} for the decoder and pulses PCWre once the
// fetch is accepted. Flush discards the queue and any in-flight read.
module instr_fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input logic CLK,
    input logic Reset,
    instr_fetch_unit_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] word;
    } entry_t;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, ERR} state_t;

    state_t                 state, state_nx;
    entry_t [DEPTH-1:0]     q;
    logic   [PTR_W-1:0]     head, tail;
    logic   [CNT_W-1:0]     count;
    logic   [ADDR_W-1:0]    addr_q;
    logic                   err_q;

    logic has_room, misaligned, push, pop, load_addr, err_set, err_clr;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign has_room   = (count < FULL);
    assign misaligned = (bus.Address[1:0] != 2'b00);
    assign pop        = bus.InstrValid && bus.InstrReady;

    assign bus.mem_addr    = addr_q;
    assign bus.AddrErr     = err_q;
    assign bus.InstrValid  = (count != '0);
    assign bus.Instruction = q[head].word;
    assign bus.InstrPC     = q[head].pc;

    // State register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state, handshake outputs and the PC-advance pulse.
    always_comb begin
        state_nx    = state;
        push        = 1'b0;
        load_addr   = 1'b0;
        err_set     = 1'b0;
        err_clr     = 1'b0;
        bus.mem_req = 1'b0;
        bus.PCWre   = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.Flush && has_room) begin
                    if (misaligned) begin
                        state_nx = ERR;
                        err_set  = 1'b1;
                    end else begin
                        state_nx  = REQ;
                        load_addr = 1'b1;
                    end
                end
            end
            REQ: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack) begin
                    state_nx = IDLE;
                    if (!bus.Flush) begin
                        push      = 1'b1;
                        bus.PCWre = 1'b1;
                    end
                end else if (bus.Flush) begin
                    // Read already issued: keep req up until memory answers.
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack) state_nx = IDLE;
            end
            ERR: begin
                if (bus.Flush) begin
                    state_nx = IDLE;
                    err_clr  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Read address latch and sticky misalignment flag.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (load_addr) addr_q <= bus.Address;
            if (err_set)      err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;
        end
    end

    // Circular instruction queue; Flush wins over same-cycle push/pop.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            q     <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.Flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                q[tail] <= '{pc: addr_q, word: bus.mem_rdata};
                tail    <= nxt(tail);
            end
            if (pop) head <= nxt(head);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations,
// a background memory responder, and a per-cycle queue-level reference model.
module tb_instr_fetch_unit;
    localparam int DEPTH = 2;

    logic CLK = 1'b0;
    logic Reset;
    int   lat, seq;
    bit   mem_on;
    int   passed = 0, total = 0;

    instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h want %h", nm, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge CLK); #2;
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!bus.mem_req && n < 30) begin tick(); n++; end
        chk(nm, bus.mem_req, 1);
    endtask

    task automatic wait_ack(input string nm);
        int n = 0;
        while (!bus.mem_ack && n < 30) begin tick(); n++; end
        chk(nm, bus.mem_ack, 1);
    endtask

    // Memory: answers a held request after lat wait cycles, data tagged by seq.
    initial begin
        int wcnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge CLK); #1;
            bus.mem_ack = 1'b0;
            if (bus.mem_req && !Reset && mem_on) begin
                if (wcnt >= lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = 32'hD000_0000 | seq;
                    seq++;
                    wcnt = 0;
                end else wcnt++;
            end else wcnt = 0;
        end
    end

    // Reference model: queue of {pc, word}, one outstanding read, sticky error.
    typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;
    ent_t        mq[$];
    bit          busy = 0, killed = 0, err_m = 0;
    logic [31:0] busy_addr = '0;

    always @(negedge CLK) begin
        bit exp_pcwre, set_err;
        if (Reset) begin
            chk("rst_req", bus.mem_req, 0);
            chk("rst_pcwre", bus.PCWre, 0);
            chk("rst_valid", bus.InstrValid, 0);
            chk("rst_err", bus.AddrErr, 0);
            mq.delete();
            busy = 0; killed = 0; err_m = 0;
        end else begin
            chk("m_valid", bus.InstrValid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("m_instr", bus.Instruction, mq[0].word);
                chk("m_pc", bus.InstrPC, mq[0].pc);
            end
            chk("m_err", bus.AddrErr, err_m);
            if (busy) begin
                chk("m_req_hold", bus.mem_req, 1);
                chk("m_addr_hold", bus.mem_addr, busy_addr);
            end else if (bus.mem_req) begin
                chk("m_issue_ok", (mq.size() < DEPTH) && !err_m && (bus.Address[1:0] == 2'b00), 1);
                chk("m_issue_addr", bus.mem_addr, bus.Address);
                busy = 1; killed = 0; busy_addr = bus.mem_addr;
            end
            exp_pcwre = busy && bus.mem_ack && !bus.Flush && !killed;
            chk("m_pcwre", bus.PCWre, exp_pcwre);
            set_err = !busy && !bus.mem_req && !err_m && !bus.Flush &&
                      (mq.size() < DEPTH) && (bus.Address[1:0] != 2'b00);
            if (bus.Flush) begin
                mq.delete();
                err_m = 0;
            end else begin
                if (bus.InstrReady && mq.size() != 0) void'(mq.pop_front());
                if (exp_pcwre) mq.push_back('{busy_addr, bus.mem_rdata});
            end
            if (busy && bus.mem_ack) begin busy = 0; killed = 0; end
            else if (busy && bus.Flush) killed = 1;
            if (set_err) err_m = 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1; bus.Address = 32'h20; bus.Flush = 1'b0; bus.InstrReady = 1'b0;
        lat = 3; mem_on = 1; seq = 0;

        // 1: reset values, then reset during an outstanding read
        tick(); tick();
        chk("t1_req", bus.mem_req, 0);
        chk("t1_pcwre", bus.PCWre, 0);
        chk("t1_err", bus.AddrErr, 0);
        chk("t1_valid", bus.InstrValid, 0);
        chk("t1_instr", bus.Instruction, 0);
        chk("t1_pc", bus.InstrPC, 0);
        chk("t1_addr", bus.mem_addr, 0);
        Reset = 1'b0;
        wait_req("t1_wait_req");
        chk("t1_req_addr", bus.mem_addr, 32'h20);
        Reset = 1'b1;
        tick();
        chk("t1_mid_req", bus.mem_req, 0);
        chk("t1_mid_valid", bus.InstrValid, 0);
        chk("t1_mid_pcwre", bus.PCWre, 0);
        chk("t1_mid_err", bus.AddrErr, 0);
        bus.Address = 32'h10; lat = 0; seq = 0;
        Reset = 1'b0;

        // 2: zero-wait fetch at 0x10
        wait_req("t2_wait_req");
        chk("t2_addr", bus.mem_addr, 32'h10);
        chk("t2_pcwre_hi", bus.PCWre, 1);
        tick();
        chk("t2_pcwre_lo", bus.PCWre, 0);
        chk("t2_valid", bus.InstrValid, 1);
        chk("t2_instr", bus.Instruction, 32'hD000_0000);
        chk("t2_pc", bus.InstrPC, 32'h10);
        repeat (6) tick();

        // 3: flush, refill with 3-cycle latency, no issue while full, wrap order
        lat = 3;
        bus.Flush = 1'b1; tick(); bus.Flush = 1'b0;
        chk("t3_flushed", bus.InstrValid, 0);
        repeat (14) tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_full_noreq", bus.mem_req, 0);
            tick();
        end
        chk("t3_head0", bus.Instruction, 32'hD000_0002);
        chk("t3_pc0", bus.InstrPC, 32'h10);
        bus.InstrReady = 1'b1; bus.Address = 32'h44; tick(); bus.InstrReady = 1'b0;
        chk("t3_head1", bus.Instruction, 32'hD000_0003);
        wait_req("t3_wait_req");
        chk("t3_addr", bus.mem_addr, 32'h44);
        repeat (8) tick();
        chk("t3_head_keep", bus.Instruction, 32'hD000_0003);

        // 6: pop across wrap, then ack coinciding with a pop
        bus.InstrReady = 1'b1; bus.Address = 32'h48; tick(); bus.InstrReady = 1'b0;
        chk("t6_wrap_instr", bus.Instruction, 32'hD000_0004);
        chk("t6_wrap_pc", bus.InstrPC, 32'h44);
        wait_ack("t6_wait_ack");
        chk("t6_pcwre", bus.PCWre, 1);
        bus.InstrReady = 1'b1; tick(); bus.InstrReady = 1'b0;
        chk("t6_valid", bus.InstrValid, 1);
        chk("t6_instr", bus.Instruction, 32'hD000_0005);
        chk("t6_pc", bus.InstrPC, 32'h48);
        repeat (8) tick();
        chk("t6_full_noreq", bus.mem_req, 0);
        chk("t6_head_keep", bus.Instruction, 32'hD000_0005);

        // 4: flush with a read in flight, drain it, data dropped
        mem_on = 0; lat = 0;
        bus.InstrReady = 1'b1; bus.Address = 32'h80; tick(); bus.InstrReady = 1'b0;
        chk("t4_head", bus.Instruction, 32'hD000_0006);
        wait_req("t4_wait_req");
        chk("t4_addr", bus.mem_addr, 32'h80);
        bus.Flush = 1'b1;
        chk("t4_pcwre_flush", bus.PCWre, 0);
        tick(); bus.Flush = 1'b0;
        chk("t4_empty", bus.InstrValid, 0);
        chk("t4_drain_req", bus.mem_req, 1);
        chk("t4_drain_addr", bus.mem_addr, 32'h80);
        tick();
        chk("t4_drain_req2", bus.mem_req, 1);
        chk("t4_drain_addr2", bus.mem_addr, 32'h80);
        mem_on = 1; bus.Address = 32'h06;
        tick();
        chk("t4_ack", bus.mem_ack, 1);
        chk("t4_no_pcwre", bus.PCWre, 0);
        tick();
        chk("t4_dropped", bus.InstrValid, 0);
        chk("t4_req_off", bus.mem_req, 0);

        // 5: misaligned PC -> sticky error until Flush, then fetch resumes
        tick();
        chk("t5_err", bus.AddrErr, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_noreq", bus.mem_req, 0);
            chk("t5_err_hold", bus.AddrErr, 1);
        end
        bus.Flush = 1'b1; bus.Address = 32'h100; tick(); bus.Flush = 1'b0;
        chk("t5_err_clr", bus.AddrErr, 0);
        wait_req("t5_wait_req");
        chk("t5_addr", bus.mem_addr, 32'h100);
        tick();
        chk("t5_valid", bus.InstrValid, 1);
        chk("t5_instr", bus.Instruction, 32'hD000_0008);
        chk("t5_pc", bus.InstrPC, 32'h100);
        repeat (4) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
